// File: rtl/res_to_bcd.sv
// rtl/res_to_bcd.sv - serial double-dabble converter from a divider result to packed BCD
// A Ready rising edge starts one conversion; the result holds until the next DONE.
module res_to_bcd #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Ready,
  input  logic [WIDTH-1:0]      Res,
  output logic                  Busy,
  output logic                  Valid,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic [DIGITS-1:0]     Blank,
  output logic                  Overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADJ   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic                  Ready_q;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adj;
  logic [DIGITS-1:0]     blank_nxt;
  logic                  zero_run;
  logic                  trig;

  assign trig = Ready & ~Ready_q;

  // Every digit that would overflow past 9 on the next doubling gets +3.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // A digit blanks only when it and every higher digit are zero; units never blank.
  always_comb begin
    blank_nxt = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (scratch[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      Ready_q <= 1'b1;
      Busy    <= 1'b0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
      Bcd     <= '0;
      Blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
      cnt     <= '0;
      bin     <= '0;
      scratch <= '0;
    end else begin
      Ready_q <= Ready;
      Valid   <= 1'b0;
      Overrun <= trig && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (trig) begin
            bin     <= Res;
            scratch <= '0;
            cnt     <= '0;
            Busy    <= 1'b1;
            state   <= S_ADJ;
          end
        end
        S_ADJ: begin
          scratch <= adj;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          scratch <= {scratch[4*DIGITS-2:0], bin[WIDTH-1]};
          bin     <= bin << 1;
          cnt     <= cnt + 1'b1;
          state   <= (cnt < LAST) ? S_ADJ : S_DONE;
        end
        S_DONE: begin
          Bcd   <= scratch;
          Blank <= blank_nxt;
          Valid <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_res_to_bcd.sv
// tb/tb_res_to_bcd.sv - directed bench for res_to_bcd
module tb_res_to_bcd;

  logic        clk;
  logic        reset;
  logic        Ready;
  logic [11:0] Res;
  logic        Busy;
  logic        Valid;
  logic [15:0] Bcd;
  logic [3:0]  Blank;
  logic        Overrun;

  int n_cmp = 0;
  int n_err = 0;

  res_to_bcd #(.WIDTH(12), .DIGITS(4)) dut (
    .clk(clk), .reset(reset), .Ready(Ready), .Res(Res),
    .Busy(Busy), .Valid(Valid), .Bcd(Bcd), .Blank(Blank), .Overrun(Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_blank(input int v);
    logic [3:0] b;
    int p;
    b = '0;
    p = 10;
    for (int i = 1; i < 4; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  // Single trigger, then 27 edges observed; edge index 0 is the trigger edge.
  task automatic do_conv(input logic [11:0] v, output int busy_n, output int valid_n,
                         output int valid_at, output int ovr_n);
    Ready = 1'b0;
    tick;
    busy_n = 0; valid_n = 0; valid_at = -1; ovr_n = 0;
    Res = v;
    Ready = 1'b1;
    for (int i = 0; i < 27; i++) begin
      tick;
      if (i == 0) Ready = 1'b0;
      if (Busy) busy_n++;
      if (Valid) begin
        valid_n++;
        if (valid_at < 0) valid_at = i;
      end
      if (Overrun) ovr_n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Ready = 1'b0; Res = '0;
    tick; tick;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", Busy); end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", Valid); end
    n_cmp++; if (Overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b want=0", Overrun); end
    n_cmp++; if (Bcd !== 16'h0000) begin n_err++; $display("FAIL reset_bcd got=%h want=0000", Bcd); end
    n_cmp++; if (Blank !== 4'b1110) begin n_err++; $display("FAIL reset_blank got=%b want=1110", Blank); end
    reset = 1'b0;
    tick;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b want=0", Busy); end
  endtask

  task automatic test_basic;
    logic [11:0] vals [4]  = '{12'd4095, 12'd0, 12'd42, 12'd7};
    logic [15:0] bcds [4]  = '{16'h4095, 16'h0000, 16'h0042, 16'h0007};
    logic [3:0]  blks [4]  = '{4'b0000, 4'b1110, 4'b1100, 4'b1110};
    int bn, vn, va, on;
    for (int t = 0; t < 4; t++) begin
      do_conv(vals[t], bn, vn, va, on);
      n_cmp++; if (bn !== 25) begin n_err++; $display("FAIL basic_busy_len res=%0d got=%0d want=25", vals[t], bn); end
      n_cmp++; if (vn !== 1) begin n_err++; $display("FAIL basic_valid_cnt res=%0d got=%0d want=1", vals[t], vn); end
      n_cmp++; if (va !== 25) begin n_err++; $display("FAIL basic_valid_at res=%0d got=%0d want=25", vals[t], va); end
      n_cmp++; if (on !== 0) begin n_err++; $display("FAIL basic_overrun res=%0d got=%0d want=0", vals[t], on); end
      n_cmp++; if (Bcd !== bcds[t]) begin n_err++; $display("FAIL basic_bcd res=%0d got=%h want=%h", vals[t], Bcd, bcds[t]); end
      n_cmp++; if (Blank !== blks[t]) begin n_err++; $display("FAIL basic_blank res=%0d got=%b want=%b", vals[t], Blank, blks[t]); end
    end
    Res = 12'd555;
    tick; tick; tick;
    n_cmp++; if (Bcd !== 16'h0007) begin n_err++; $display("FAIL basic_hold got=%h want=0007", Bcd); end
  endtask

  task automatic test_hold;
    int vn = 0;
    Ready = 1'b0;
    tick;
    Res = 12'd1000;
    Ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (i == 0) Res = 12'd55;
      if (Valid) vn++;
    end
    Ready = 1'b0;
    tick;
    n_cmp++; if (vn !== 1) begin n_err++; $display("FAIL hold_valid_cnt got=%0d want=1", vn); end
    n_cmp++; if (Bcd !== 16'h1000) begin n_err++; $display("FAIL hold_bcd got=%h want=1000", Bcd); end
    n_cmp++; if (Blank !== 4'b0000) begin n_err++; $display("FAIL hold_blank got=%b want=0000", Blank); end
  endtask

  task automatic test_overrun;
    int on = 0, oa = -1, vn = 0, va = -1;
    Ready = 1'b0;
    tick;
    Res = 12'd123;
    for (int i = 0; i < 28; i++) begin
      Ready = (i == 0 || i == 10);
      if (i == 1) Res = 12'd999;
      tick;
      if (Overrun) begin on++; if (oa < 0) oa = i; end
      if (Valid) begin vn++; if (va < 0) va = i; end
    end
    Ready = 1'b0;
    n_cmp++; if (on !== 1) begin n_err++; $display("FAIL ovr_cnt got=%0d want=1", on); end
    n_cmp++; if (oa !== 10) begin n_err++; $display("FAIL ovr_at got=%0d want=10", oa); end
    n_cmp++; if (vn !== 1) begin n_err++; $display("FAIL ovr_valid_cnt got=%0d want=1", vn); end
    n_cmp++; if (va !== 25) begin n_err++; $display("FAIL ovr_valid_at got=%0d want=25", va); end
    n_cmp++; if (Bcd !== 16'h0123) begin n_err++; $display("FAIL ovr_bcd got=%h want=0123", Bcd); end
    n_cmp++; if (Blank !== 4'b1000) begin n_err++; $display("FAIL ovr_blank got=%b want=1000", Blank); end
  endtask

  task automatic test_done_trigger;
    int on = 0, oa = -1, vn = 0, late_busy = 0;
    Ready = 1'b0;
    tick;
    Res = 12'd321;
    for (int i = 0; i < 30; i++) begin
      Ready = (i == 0 || i >= 25);
      tick;
      if (Overrun) begin on++; if (oa < 0) oa = i; end
      if (Valid) vn++;
      if (i >= 25 && Busy) late_busy++;
    end
    Ready = 1'b0;
    n_cmp++; if (on !== 1) begin n_err++; $display("FAIL done_ovr_cnt got=%0d want=1", on); end
    n_cmp++; if (oa !== 25) begin n_err++; $display("FAIL done_ovr_at got=%0d want=25", oa); end
    n_cmp++; if (vn !== 1) begin n_err++; $display("FAIL done_valid_cnt got=%0d want=1", vn); end
    n_cmp++; if (late_busy !== 0) begin n_err++; $display("FAIL done_no_restart got=%0d want=0", late_busy); end
    n_cmp++; if (Bcd !== 16'h0321) begin n_err++; $display("FAIL done_bcd got=%h want=0321", Bcd); end
  endtask

  task automatic test_back_to_back;
    int on = 0;
    Ready = 1'b0;
    tick;
    for (int i = 0; i < 53; i++) begin
      Ready = (i == 0 || i == 26);
      Res = (i < 26) ? 12'd250 : 12'd3;
      tick;
      if (Overrun) on++;
      if (i == 25) begin
        n_cmp++; if (Valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid1 got=%b want=1", Valid); end
        n_cmp++; if (Bcd !== 16'h0250) begin n_err++; $display("FAIL b2b_bcd1 got=%h want=0250", Bcd); end
        n_cmp++; if (Blank !== 4'b1000) begin n_err++; $display("FAIL b2b_blank1 got=%b want=1000", Blank); end
      end
      if (i == 51) begin
        n_cmp++; if (Valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2 got=%b want=1", Valid); end
        n_cmp++; if (Bcd !== 16'h0003) begin n_err++; $display("FAIL b2b_bcd2 got=%h want=0003", Bcd); end
        n_cmp++; if (Blank !== 4'b1110) begin n_err++; $display("FAIL b2b_blank2 got=%b want=1110", Blank); end
      end
    end
    Ready = 1'b0;
    n_cmp++; if (on !== 0) begin n_err++; $display("FAIL b2b_overrun got=%0d want=0", on); end
  endtask

  task automatic test_reset_mid;
    int vn = 0, bn = 0, on = 0;
    Ready = 1'b0;
    tick;
    Res = 12'd777;
    for (int i = 0; i < 12; i++) begin
      Ready = (i == 0);
      tick;
    end
    reset = 1'b1;
    Ready = 1'b1;
    tick; tick;
    reset = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b want=0", Busy); end
    for (int i = 0; i < 30; i++) begin
      tick;
      if (Valid) vn++;
      if (Busy) bn++;
      if (Overrun) on++;
    end
    Ready = 1'b0;
    n_cmp++; if (vn !== 0) begin n_err++; $display("FAIL rmid_valid got=%0d want=0", vn); end
    n_cmp++; if (bn !== 0) begin n_err++; $display("FAIL rmid_restart got=%0d want=0", bn); end
    n_cmp++; if (on !== 0) begin n_err++; $display("FAIL rmid_overrun got=%0d want=0", on); end
    n_cmp++; if (Bcd !== 16'h0000) begin n_err++; $display("FAIL rmid_bcd got=%h want=0000", Bcd); end
    n_cmp++; if (Blank !== 4'b1110) begin n_err++; $display("FAIL rmid_blank got=%b want=1110", Blank); end
  endtask

  task automatic test_sweep;
    logic [15:0] eb;
    logic [3:0]  ek;
    Ready = 1'b0;
    tick;
    for (int v = 0; v < 4096; v += 3) begin
      eb = ref_bcd(v);
      ek = ref_blank(v);
      Res = 12'(v);
      Ready = 1'b1;
      tick;
      Ready = 1'b0;
      repeat (25) tick;
      n_cmp++; if (Valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid res=%0d got=%b want=1", v, Valid); end
      n_cmp++; if (Bcd !== eb) begin n_err++; $display("FAIL sweep_bcd res=%0d got=%h want=%h", v, Bcd, eb); end
      n_cmp++; if (Blank !== ek) begin n_err++; $display("FAIL sweep_blank res=%0d got=%b want=%b", v, Blank, ek); end
    end
  endtask

  initial begin
    reset = 1'b1;
    Ready = 1'b0;
    Res   = '0;
    test_reset;
    test_basic;
    test_hold;
    test_overrun;
    test_done_trigger;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
